// File: rtl/clk_ctrl_pkg.sv
// Shared types and default timing constants for the CPU clock-source switch sequencer.
// No logic here; the FSM state encoding and cycle counts are used by clk_switch_ctrl.
package clk_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_QUIESCE,
    ST_WIZ_RST,
    ST_WAIT_LOCK,
    ST_SETTLE
  } state_t;

  localparam int unsigned DEF_CNT_W        = 16;
  localparam int unsigned DEF_QUIESCE_CYC  = 16;
  localparam int unsigned DEF_WIZ_RST_CYC  = 8;
  localparam int unsigned DEF_LOCK_TIMEOUT = 50000;
  localparam int unsigned DEF_SETTLE_CYC   = 64;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single slow asynchronous level.
// Latency: two clk edges; no backpressure.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/clk_switch_ctrl.sv
// Sequences a glitch-safe CPU clock-source switch (sys_clock <-> Clock Wizard), holding the CPU in reset.
// All outputs registered; cfg_update is dropped (not queued) whenever busy.
module clk_switch_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W        = DEF_CNT_W,
  parameter int unsigned QUIESCE_CYC  = DEF_QUIESCE_CYC,
  parameter int unsigned WIZ_RST_CYC  = DEF_WIZ_RST_CYC,
  parameter int unsigned LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int unsigned SETTLE_CYC   = DEF_SETTLE_CYC
) (
  input  logic sys_clock,
  input  logic reset,
  input  logic cfg_use_wiz,
  input  logic cfg_update,
  input  logic clk_wiz_locked,
  output logic clk_wiz_enable,
  output logic clk_wiz_reset,
  output logic cpu_reset,
  output logic busy,
  output logic done,
  output logic err_timeout,
  output logic err_lock_lost
);

  localparam logic [CNT_W-1:0] QUIESCE_LAST = CNT_W'(QUIESCE_CYC - 1);
  localparam logic [CNT_W-1:0] WIZ_RST_LAST = CNT_W'(WIZ_RST_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             lock_s;
  logic             target, target_nxt;
  logic             en_nxt, wrst_nxt, crst_nxt, done_nxt, errt_nxt, errl_nxt;

  sync_2ff #(.RST_VAL(1'b0)) u_lock_sync (
    .clk   (sys_clock),
    .reset (reset),
    .d     (clk_wiz_locked),
    .q     (lock_s)
  );

  always_comb begin
    state_nxt  = state;
    target_nxt = target;
    en_nxt     = clk_wiz_enable;
    wrst_nxt   = clk_wiz_reset;
    crst_nxt   = cpu_reset;
    done_nxt   = 1'b0;
    errt_nxt   = err_timeout;
    errl_nxt   = err_lock_lost;

    case (state)
      ST_RUN: begin
        // Lock loss outranks a coincident update, which is simply dropped.
        if (clk_wiz_enable && !lock_s) begin
          crst_nxt  = 1'b1;
          en_nxt    = 1'b0;
          errl_nxt  = 1'b1;
          state_nxt = ST_SETTLE;
        end else if (cfg_update && (cfg_use_wiz != clk_wiz_enable)) begin
          target_nxt = cfg_use_wiz;
          errt_nxt   = 1'b0;
          errl_nxt   = 1'b0;
          crst_nxt   = 1'b1;
          state_nxt  = ST_QUIESCE;
        end
      end
      ST_QUIESCE: begin
        crst_nxt = 1'b1;
        if (cnt == QUIESCE_LAST) begin
          en_nxt = 1'b0;
          if (target) begin
            wrst_nxt  = 1'b1;
            state_nxt = ST_WIZ_RST;
          end else begin
            state_nxt = ST_SETTLE;
          end
        end
      end
      ST_WIZ_RST: begin
        if (cnt == WIZ_RST_LAST) begin
          wrst_nxt  = 1'b0;
          state_nxt = ST_WAIT_LOCK;
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          en_nxt    = 1'b1;
          state_nxt = ST_SETTLE;
        end else if (cnt == TIMEOUT_LAST) begin
          errt_nxt  = 1'b1;
          state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        crst_nxt = 1'b1;
        if (cnt == SETTLE_LAST) begin
          crst_nxt  = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      default: begin
        crst_nxt  = 1'b1;
        en_nxt    = 1'b0;
        wrst_nxt  = 1'b0;
        state_nxt = ST_SETTLE;
      end
    endcase

    // RUN has no timed exit, so the counter is frozen there to keep it from wrapping.
    if (state_nxt != state) begin
      cnt_nxt = '0;
    end else if (state == ST_RUN) begin
      cnt_nxt = cnt;
    end else begin
      cnt_nxt = cnt + 1'b1;
    end
  end

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      state          <= ST_SETTLE;
      cnt            <= '0;
      target         <= 1'b0;
      clk_wiz_enable <= 1'b0;
      clk_wiz_reset  <= 1'b0;
      cpu_reset      <= 1'b1;
      done           <= 1'b0;
      err_timeout    <= 1'b0;
      err_lock_lost  <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      target         <= target_nxt;
      clk_wiz_enable <= en_nxt;
      clk_wiz_reset  <= wrst_nxt;
      cpu_reset      <= crst_nxt;
      done           <= done_nxt;
      err_timeout    <= errt_nxt;
      err_lock_lost  <= errl_nxt;
    end
  end

  assign busy = (state != ST_RUN);

endmodule
